// File: rtl/conn_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : conn_rr_arbiter_if
// Purpose  : Requester-side and output-side handshake bundle for the arbiter.
// Revision : 1.0
// ============================================================================
interface conn_rr_arbiter_if #(
  parameter int WIDTH = 1,
  parameter int NREQ  = 4
);
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SRCW-1:0]       out_src;
  logic                  out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/conn_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conn_rr_arbiter
// Purpose  : Round-robin arbiter feeding one registered, source-tagged channel.
// Revision : 1.0
// ============================================================================
module conn_rr_arbiter #(
  parameter int WIDTH = 1,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  conn_rr_arbiter_if.slave bus
);
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [SRCW-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SRCW-1:0]  r_out_src;

  logic             w_can_accept;
  logic             w_any;
  logic [SRCW-1:0]  w_gidx;
  logic [SRCW:0]    w_sum;
  logic [NREQ-1:0]  w_grant;

  assign w_can_accept = (r_state == ST_EMPTY) | bus.out_ready;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_sum  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (SRCW+1)'(k);
      if (w_sum >= (SRCW+1)'(NREQ)) begin
        w_sum = w_sum - (SRCW+1)'(NREQ);
      end
      if (bus.req_valid[w_sum[SRCW-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_sum[SRCW-1:0];
      end
    end
  end

  assign w_grant       = w_any ? (NREQ'(1) << w_gidx) : '0;
  assign bus.req_ready = w_grant & {NREQ{w_can_accept}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_any && w_can_accept) begin
      r_state     <= ST_FULL;
      r_out_valid <= 1'b1;
      r_out_data  <= bus.req_data[w_gidx*WIDTH +: WIDTH];
      r_out_src   <= w_gidx;
      r_ptr       <= (w_gidx == SRCW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    end else if ((r_state == ST_FULL) && bus.out_ready) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_src)));

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_chk
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_valid[gi] && !bus.req_ready[gi]) |=>
        (bus.req_valid[gi] && $stable(bus.req_data[gi*WIDTH +: WIDTH])));
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_conn_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_conn_rr_arbiter
// Purpose  : Vector table, corner sequences and random model check of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_conn_rr_arbiter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  conn_rr_arbiter_if #(.WIDTH(8), .NREQ(4)) b4 ();
  conn_rr_arbiter_if #(.WIDTH(8), .NREQ(3)) b3 ();

  conn_rr_arbiter #(.WIDTH(8), .NREQ(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  conn_rr_arbiter #(.WIDTH(8), .NREQ(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [31:0] data;
    bit          ordy;
    logic [3:0]  exp_rdy;
    bit          exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_os;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] v, logic [31:0] d, bit ordy,
                              logic [3:0] er, bit eov, logic [7:0] eod, logic [1:0] eos);
    vec_t t;
    t.rst = rst; t.valid = v; t.data = d; t.ordy = ordy;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_os = eos;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    b4.req_valid = '0; b4.req_data = '0; b4.out_ready = 1'b0;
    b3.req_valid = '0; b3.req_data = '0; b3.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] D  = 32'h13121110;
  localparam logic [31:0] D2 = 32'h13A51110;

  // Reference-model state for the random phase
  int         m_ptr;
  bit         m_full;
  logic [7:0] m_data;
  int         m_src;
  logic [3:0] pv;
  logic [7:0] pd [4];

  initial begin
    logic [3:0] er;
    logic [7:0] eod;
    logic [1:0] eos;
    bit         can;
    int         g;
    logic [2:0] er3;
    int         src3;

    errors = 0;
    checks = 0;
    rst_n  = 1'b1;
    b4.req_valid = '0; b4.req_data = '0; b4.out_ready = 1'b0;
    b3.req_valid = '0; b3.req_data = '0; b3.out_ready = 1'b0;

    // Reset then idle
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(k == 0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0));

    // Single requester, then pointer lands on 3
    tbl.push_back(mk(1'b1, 4'b0100, D2, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0));
    tbl.push_back(mk(1'b0, 4'b0000, D2, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2));
    tbl.push_back(mk(1'b0, 4'b1111, D,  1'b1, 4'b1000, 1'b0, 8'hA5, 2'd2));

    // All-valid round robin from reset
    for (int k = 0; k < 9; k++) begin
      er  = 4'(1 << (k % 4));
      eos = (k > 0) ? 2'((k - 1) % 4) : 2'd0;
      eod = (k > 0) ? 8'(8'h10 + (k - 1) % 4) : 8'h00;
      tbl.push_back(mk(k == 0, 4'b1111, D, 1'b1, er, k > 0, eod, eos));
    end

    // Backpressure with pointer skip over an idle requester
    tbl.push_back(mk(1'b1, 4'b0010, D, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b0, 4'b1011, D, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk(1'b0, 4'b1011, D, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk(1'b0, 4'b0011, D, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3));
    tbl.push_back(mk(1'b0, 4'b0010, D, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0));
    tbl.push_back(mk(1'b0, 4'b0000, D, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk(1'b0, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      else @(negedge clk);
      b4.req_valid = tbl[i].valid;
      b4.req_data  = tbl[i].data;
      b4.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_req_ready", i), 64'(b4.req_ready), 64'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(b4.out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("vec%0d_out_data", i),  64'(b4.out_data),  64'(tbl[i].exp_od));
      chk($sformatf("vec%0d_out_src", i),   64'(b4.out_src),   64'(tbl[i].exp_os));
    end

    // NREQ=3 wrap: requester 2 first, then 2 and 0 alternate
    do_reset();
    b3.req_data  = 24'h323130;
    b3.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      b3.req_valid = (k == 0) ? 3'b100 : 3'b101;
      #1;
      er3 = (k % 2 == 1) ? 3'b001 : 3'b100;
      chk($sformatf("wrap3_k%0d_req_ready", k), 64'(b3.req_ready), 64'(er3));
      if (k > 0) begin
        src3 = ((k - 1) % 2 == 0) ? 2 : 0;
        chk($sformatf("wrap3_k%0d_out_src", k),  64'(b3.out_src),  64'(src3));
        chk($sformatf("wrap3_k%0d_out_data", k), 64'(b3.out_data), 64'(8'h30 + src3));
      end
    end

    // Asynchronous reset while stalled
    do_reset();
    b4.req_valid = 4'b0100; b4.req_data = D; b4.out_ready = 1'b0;
    @(negedge clk);
    b4.req_valid = 4'b0000;
    #1;
    chk("stall_out_valid", 64'(b4.out_valid), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(b4.out_valid), 64'(0));
    chk("async_rst_out_data",  64'(b4.out_data),  64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b4.req_valid = 4'b1111; b4.out_ready = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(b4.req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    chk("post_rst_out_src",   64'(b4.out_src),   64'(0));
    chk("post_rst_out_data",  64'(b4.out_data),  64'(8'h10));

    // Randomized traffic against the reference model
    do_reset();
    m_ptr = 0; m_full = 1'b0; m_data = 8'h00; m_src = 0; pv = '0;
    for (int i = 0; i < 4; i++) pd[i] = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pd[i] = 8'($urandom);
        end
      end
      b4.req_valid = pv;
      b4.req_data  = {pd[3], pd[2], pd[1], pd[0]};
      b4.out_ready = ($urandom_range(0, 3) != 0);

      can = !m_full || b4.out_ready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && pv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      er = (can && g >= 0) ? 4'(1 << g) : 4'b0000;

      #1;
      chk("rand_req_ready", 64'(b4.req_ready), 64'(er));
      chk("rand_out_valid", 64'(b4.out_valid), 64'(m_full));
      chk("rand_out_data",  64'(b4.out_data),  64'(m_data));
      chk("rand_out_src",   64'(b4.out_src),   64'(m_src));

      @(posedge clk);
      if (can && g >= 0) begin
        m_full = 1'b1;
        m_data = pd[g];
        m_src  = g;
        m_ptr  = (g + 1) % 4;
        pv[g]  = 1'b0;
      end else if (m_full && b4.out_ready) begin
        m_full = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conn_rr_arbiter.md
Name: conn_rr_arbiter

Overview:
- Round-robin arbiter sharing one WIDTH-bit pass-through channel between NREQ requesters.
- Each requester offers data with a valid/ready handshake. The winner's data is captured into a single output register stage, tagged with its source index, and presented downstream with valid/ready.
- Sits in front of the shared connect/sub pass-through path. It sequences which requester drives the channel, one word per handshake.

Parameters:
- WIDTH, 1, data width of each requester and of the output channel (1..64).
- NREQ, 4, number of requesters (2..16).
- SRCW, $clog2(NREQ), width of the source index (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i offers a word.
- req_data  input  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  bit i: requester i's word is accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_src  output  SRCW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=0, state=EMPTY. req_ready is combinationally 0 while the state is EMPTY and no req_valid is high.
- State machine:
  - EMPTY (output register free).
  - FULL (holding a word, waiting on out_ready).
- can_accept = (state==EMPTY) | out_ready. A new word may load in the same cycle the old word drains; there is no bubble.
- Grant selection (combinational):
  - Pick the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... NREQ-1, 0, ... rr_ptr-1 (modulo NREQ).
  - grant one-hot; zero if no req_valid.
  - req_ready = grant & {NREQ{can_accept}}.
- Handshake on requester i (req_valid[i] & req_ready[i]), at the clock edge:
  - out_data <= word i; out_src <= i; out_valid <= 1; state <= FULL.
  - rr_ptr <= (i==NREQ-1) ? 0 : i+1.
- Output drain without new grant (state FULL, out_ready=1, no req_valid): out_valid <= 0; state <= EMPTY; out_data and out_src hold their last values.
- Stall (state FULL, out_ready=0):
  - All req_ready=0.
  - out_data, out_src and out_valid hold.
  - rr_ptr holds.
- rr_ptr advances only on an accepted handshake. It never advances on idle cycles or stalls.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N (1 cycle). Sustained throughput is 1 word/cycle with out_ready tied high.
- Fairness: with all NREQ requesters continuously valid and out_ready=1, grants cycle 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 grants.
- Requester rules (checked by assertion, not corrected by RTL):
  - Once req_valid[i] is high, it stays high and req_data[i] stays stable until req_ready[i].
  - out_ready may toggle freely.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_src must not change (assertion).
- Reset mid-transfer: a pending word is discarded, out_valid drops asynchronously, and arbitration restarts at requester 0.
- NREQ not a power of two: pointer wrap uses explicit compare to NREQ-1. Indices >= NREQ are never produced.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, release, no req_valid.
   - Response: out_valid=0, out_data=0, out_src=0, req_ready=0 for 10 cycles.
2. Single requester, WIDTH=8, NREQ=4: req_valid=4'b0100, data2=8'hA5, out_ready=1.
   - Response: req_ready=4'b0100 on the first cycle; next cycle out_valid=1, out_data=A5, out_src=2; rr_ptr=3.
3. All-valid round robin: req_valid=4'b1111, data i = 8'h10+i, out_ready=1 for 8 cycles.
   - Response: out_src sequence 0,1,2,3,0,1,2,3; out_data 10,11,12,13,10,11,12,13.
4. Backpressure: word from requester 1 loaded, out_ready=0 for 4 cycles with req_valid=4'b1011.
   - During the stall: req_ready=0; out_data and out_src are stable at 1.
   - out_ready=1: the same cycle grants requester 3 (pointer=2, 2 invalid). The next word shows out_src=3.
5. Wrap with NREQ=3 (non-power-of-two): only requesters 2 and 0 valid.
   - Response: alternating out_src 2,0,2,0; never 3.
6. Async reset mid-stall: out_valid=1, out_ready=0, assert rst_n low between clock edges.
   - Response: out_valid=0 immediately. After release with req_valid=4'b1111, the first grant is requester 0.
